// File: rtl/i2s_video_stream_tx_pkg.sv
// Shared types and helpers for the video-over-I2S transmitter.
// Pixel packing modes, status-word bit offsets, RGB888 packing function.
package i2s_video_pkg;

   typedef enum logic {
      PACK_RGB565 = 1'b0,
      PACK_RGB555 = 1'b1
   } pack_mode_e;

   // Status bits counted down from the slot MSB: index = SLOT_W - OFS
   localparam int STATUS_VALID_OFS = 1;
   localparam int STATUS_SOF_OFS   = 2;

   function automatic logic [15:0] pack_pixel(
      input pack_mode_e  mode,
      input logic [23:0] rgb
   );
      logic [15:0] w;
      if (mode == PACK_RGB555)
         w = {1'b0, rgb[23:19], rgb[15:11], rgb[7:3]};
      else
         w = {rgb[23:19], rgb[15:10], rgb[7:3]};
      return w;
   endfunction

endpackage

// File: rtl/i2s_video_stream_tx_if.sv
// Pixel-source and I2S-link signal bundle for i2s_video_stream_tx.
// slave = transmitter side, master = pixel source / link observer.
interface i2s_video_stream_tx_if;
   logic        cts;
   logic        v_sync;
   logic        datavalid;
   logic [23:0] disp_data;
   logic        pclk;
   logic        i2s_bclk;
   logic        i2s_ws;
   logic        i2s_data;
   logic        overflow;

   modport master (
      output cts, v_sync, datavalid, disp_data,
      input  pclk, i2s_bclk, i2s_ws, i2s_data, overflow
   );

   modport slave (
      input  cts, v_sync, datavalid, disp_data,
      output pclk, i2s_bclk, i2s_ws, i2s_data, overflow
   );
endinterface

// File: rtl/i2s_video_stream_tx_pix_fifo.sv
// Synchronous pixel FIFO, first-word-fall-through read (dout = head).
// Ports: clk, reset (sync, high), push/din, pop/dout, full, empty.
module i2s_pix_fifo #(
   parameter int WIDTH = 17,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;

   // Extra pointer bit distinguishes full from empty
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                  (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign dout  = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push && !full)
            wr_ptr <= wr_ptr + PW'(1);
         if (pop && !empty)
            rd_ptr <= rd_ptr + PW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push && !full)
         mem[wr_ptr[AW-1:0]] <= din;
   end
endmodule

// File: rtl/i2s_video_stream_tx.sv
// RGB888 pixel capture, packing, FIFO and two-slot I2S serialiser.
// Ports: mclk, reset (sync, high), bus (slave): pixel in, I2S out, overflow.
module i2s_video_stream_tx #(
   parameter int SLOT_W     = 16,
   parameter int BCLK_DIV   = 1,
   parameter int FIFO_DEPTH = 8,
   parameter int PACK_MODE  = 0
) (
   input  logic                 mclk,
   input  logic                 reset,
   i2s_video_stream_tx_if.slave bus
);
   import i2s_video_pkg::*;

   localparam int BW = $clog2(SLOT_W);
   localparam int DW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
   localparam int CW = SLOT_W - 2;

   localparam logic [BW-1:0] BIT_LAST = BW'(SLOT_W - 1);
   localparam logic [BW-1:0] BIT_LEAD = BW'(SLOT_W - 2);
   localparam logic [DW-1:0] DIV_LAST = DW'(BCLK_DIV - 1);

   localparam logic [0:0] SLOT_LEFT  = 1'b0;
   localparam logic [0:0] SLOT_RIGHT = 1'b1;

   localparam pack_mode_e MODE =
      (PACK_MODE != 0) ? PACK_RGB555 : PACK_RGB565;

   logic [DW-1:0]   div_cnt;
   logic            bclk;
   logic [BW-1:0]   bitcnt;
   logic [0:0]      slot;
   logic            ws;
   logic            pclk_q;
   logic            ovf;
   logic [SLOT_W-1:0] shreg;
   logic [SLOT_W-1:0] right_word;
   logic [SLOT_W-1:0] next_status;
   logic [SLOT_W-1:0] pix_word;
   logic [CW-1:0]   frame_cnt;
   logic            sof_pending;
   logic            prev_vs;

   logic            bclk_fall;
   logic            strobe;
   logic            load_left;
   logic            vs_rise;
   logic            sof_now;
   logic            push_req;
   logic            fifo_push;
   logic            fifo_pop;
   logic            fifo_full;
   logic            fifo_empty;
   logic [SLOT_W:0] fifo_din;
   logic [SLOT_W:0] fifo_dout;

   assign bclk_fall = bclk && (div_cnt == DIV_LAST);
   // Right-slot load doubles as the pixel capture strobe
   assign strobe    = bclk_fall && (bitcnt == BIT_LAST) &&
                      (slot == SLOT_LEFT);
   assign load_left = bclk_fall && (bitcnt == BIT_LAST) &&
                      (slot == SLOT_RIGHT);

   assign vs_rise   = bus.v_sync && !prev_vs;
   assign sof_now   = sof_pending || vs_rise;
   assign push_req  = strobe && bus.cts && bus.datavalid;
   assign fifo_push = push_req && !fifo_full;
   assign fifo_pop  = load_left && !fifo_empty;
   assign pix_word  = SLOT_W'(pack_pixel(MODE, bus.disp_data));
   assign fifo_din  = {sof_now, pix_word};

   always_comb begin
      next_status = '0;
      next_status[CW-1:0] = frame_cnt;
      next_status[SLOT_W-STATUS_VALID_OFS] = !fifo_empty;
      next_status[SLOT_W-STATUS_SOF_OFS] =
         !fifo_empty && fifo_dout[SLOT_W];
   end

   i2s_pix_fifo #(
      .WIDTH (SLOT_W + 1),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (mclk),
      .reset (reset),
      .push  (fifo_push),
      .din   (fifo_din),
      .pop   (fifo_pop),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_ff @(posedge mclk) begin
      if (reset) begin
         div_cnt     <= '0;
         bclk        <= 1'b0;
         bitcnt      <= '0;
         slot        <= SLOT_LEFT;
         ws          <= 1'b0;
         pclk_q      <= 1'b0;
         ovf         <= 1'b0;
         shreg       <= '0;
         right_word  <= '0;
         frame_cnt   <= '0;
         sof_pending <= 1'b0;
         prev_vs     <= 1'b0;
      end else begin
         if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            bclk    <= ~bclk;
         end else begin
            div_cnt <= div_cnt + DW'(1);
         end

         if (bclk_fall) begin
            // ws leads the slot MSB by one bit
            if (bitcnt == BIT_LEAD)
               ws <= ~ws;
            if (bitcnt == BIT_LAST) begin
               bitcnt <= '0;
               slot   <= ~slot;
               unique case (slot)
                  SLOT_LEFT: begin
                     shreg  <= right_word;
                     pclk_q <= 1'b1;
                  end
                  SLOT_RIGHT: begin
                     pclk_q     <= 1'b0;
                     right_word <= next_status;
                     shreg      <= fifo_empty ? '0 :
                                   fifo_dout[SLOT_W-1:0];
                  end
               endcase
            end else begin
               bitcnt <= bitcnt + BW'(1);
               shreg  <= {shreg[SLOT_W-2:0], 1'b0};
            end
         end

         if (strobe) begin
            prev_vs     <= bus.v_sync;
            sof_pending <= fifo_push ? 1'b0 : sof_now;
            if (vs_rise)
               frame_cnt <= frame_cnt + CW'(1);
            if (push_req && fifo_full)
               ovf <= 1'b1;
         end
      end
   end

   assign bus.pclk     = pclk_q;
   assign bus.i2s_bclk = bclk;
   assign bus.i2s_ws   = ws;
   assign bus.i2s_data = shreg[SLOT_W-1];
   assign bus.overflow = ovf;
endmodule

// File: tb/tb_i2s_video_stream_tx.sv
// Directed bench for i2s_video_stream_tx (SLOT_W=16, BCLK_DIV=1).
// Three instances: RGB565, RGB555, and a 2-deep FIFO for overflow.
module tb_i2s_video_stream_tx;

   logic mclk  = 1'b0;
   logic reset = 1'b1;
   always #5 mclk = ~mclk;

   i2s_video_stream_tx_if b0 ();
   i2s_video_stream_tx_if b1 ();
   i2s_video_stream_tx_if b2 ();

   assign b1.cts       = b0.cts;
   assign b1.v_sync    = b0.v_sync;
   assign b1.datavalid = b0.datavalid;
   assign b1.disp_data = b0.disp_data;
   assign b2.cts       = b0.cts;
   assign b2.v_sync    = b0.v_sync;
   assign b2.datavalid = b0.datavalid;
   assign b2.disp_data = b0.disp_data;

   i2s_video_stream_tx #(.SLOT_W(16), .BCLK_DIV(1),
      .FIFO_DEPTH(8), .PACK_MODE(0)) u0 (
      .mclk(mclk), .reset(reset), .bus(b0));
   i2s_video_stream_tx #(.SLOT_W(16), .BCLK_DIV(1),
      .FIFO_DEPTH(8), .PACK_MODE(1)) u1 (
      .mclk(mclk), .reset(reset), .bus(b1));
   i2s_video_stream_tx #(.SLOT_W(16), .BCLK_DIV(1),
      .FIFO_DEPTH(2), .PACK_MODE(0)) u2 (
      .mclk(mclk), .reset(reset), .bus(b2));

   int tests_run    = 0;
   int tests_failed = 0;

   // Bench frame phase: index of the last mclk edge within a 64-edge frame
   logic [5:0] ph = 6'd0;
   always @(posedge mclk) ph <= reset ? 6'd0 : ph + 6'd1;

   // Deserialise {left,right} per frame, sampling while bclk is high
   logic [31:0] sr0, sr1;
   logic [31:0] q0[$];
   logic [31:0] q1[$];
   always @(negedge mclk) begin
      if (ph[0]) begin
         sr0 = {sr0[30:0], b0.i2s_data};
         sr1 = {sr1[30:0], b1.i2s_data};
         if (ph == 6'd63) begin
            q0.push_back(sr0);
            q1.push_back(sr1);
         end
      end
   end

   task automatic set_in(input logic c, input logic v,
                         input logic d, input logic [23:0] px);
      b0.cts       = c;
      b0.v_sync    = v;
      b0.datavalid = d;
      b0.disp_data = px;
   endtask

   task automatic wait_ph(input logic [5:0] t);
      int n = 0;
      do begin
         @(negedge mclk);
         n++;
      end while (ph != t && n < 200);
   endtask

   task automatic collect(input int n);
      int c = 0;
      while (q0.size() < n && c < 2000) begin
         @(negedge mclk);
         #1;
         c++;
      end
   endtask

   task automatic apply_reset();
      @(negedge mclk);
      reset = 1'b1;
      @(negedge mclk);
      reset = 1'b0;
      q0.delete();
      q1.delete();
   endtask

   task automatic test_reset();
      logic [4:0] o;
      set_in(1'b0, 1'b0, 1'b0, 24'h0);
      reset = 1'b1;
      repeat (3) @(negedge mclk);
      o = {b0.pclk, b0.i2s_bclk, b0.i2s_ws, b0.i2s_data, b0.overflow};
      tests_run++;
      if (o !== 5'b0) begin
         tests_failed++;
         $display("FAIL reset_outputs: got %b want 00000", o);
      end
      tests_run++;
      if (b2.overflow !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_ovf_u2: got %b want 0", b2.overflow);
      end
      reset = 1'b0;
      q0.delete();
      q1.delete();
   endtask

   task automatic test_idle();
      logic [31:0] e [3];
      e = '{32'h0000_0000, 32'h0000_0001, 32'h0000_0001};
      set_in(1'b0, 1'b0, 1'b0, 24'h0);
      apply_reset();
      b0.v_sync = 1'b1;
      collect(3);
      tests_run++;
      if (q0.size() < 3) begin
         tests_failed++;
         $display("FAIL idle_frames: got %0d want 3", q0.size());
      end
      for (int i = 0; i < 3; i++) begin
         tests_run++;
         if (q0[i] !== e[i] || q1[i] !== e[i]) begin
            tests_failed++;
            $display("FAIL idle_frame%0d: got %h/%h want %h",
                     i, q0[i], q1[i], e[i]);
         end
      end
   endtask

   task automatic test_protocol();
      logic [2:0] got, exp;
      logic prev_d = 1'b0;
      set_in(1'b1, 1'b0, 1'b1, 24'h8fff7f);
      apply_reset();
      for (int i = 0; i < 128; i++) begin
         @(negedge mclk);
         exp = {ph[0], (ph >= 6'd30 && ph <= 6'd61), ph >= 6'd32};
         got = {b0.i2s_bclk, b0.i2s_ws, b0.pclk};
         tests_run++;
         if (got !== exp) begin
            tests_failed++;
            $display("FAIL proto_ph%0d: bclk/ws/pclk got %b want %b",
                     ph, got, exp);
         end
         if (ph[0]) begin
            tests_run++;
            if (b0.i2s_data !== prev_d) begin
               tests_failed++;
               $display("FAIL proto_data_stable_ph%0d: got %b want %b",
                        ph, b0.i2s_data, prev_d);
            end
         end else begin
            prev_d = b0.i2s_data;
         end
      end
   endtask

   task automatic test_pixel_stream();
      logic [23:0] d  [4];
      logic [31:0] e0 [5];
      logic [31:0] e1 [5];
      d  = '{24'h8fff7f, 24'h123456, 24'hffffff, 24'h000000};
      e0 = '{32'h0, 32'h8FEF_8000, 32'h11AA_8000,
             32'hFFFF_8000, 32'h0000_8000};
      e1 = '{32'h0, 32'h47EF_8000, 32'h08CA_8000,
             32'h7FFF_8000, 32'h0000_8000};
      set_in(1'b1, 1'b0, 1'b1, d[0]);
      apply_reset();
      for (int k = 1; k < 4; k++) begin
         wait_ph(6'd40);
         b0.disp_data = d[k];
      end
      collect(5);
      tests_run++;
      if (q0.size() < 5) begin
         tests_failed++;
         $display("FAIL stream_frames: got %0d want 5", q0.size());
      end
      for (int i = 0; i < 5; i++) begin
         tests_run++;
         if (q0[i] !== e0[i]) begin
            tests_failed++;
            $display("FAIL stream565_%0d: got %h want %h",
                     i, q0[i], e0[i]);
         end
         tests_run++;
         if (q1[i] !== e1[i]) begin
            tests_failed++;
            $display("FAIL stream555_%0d: got %h want %h",
                     i, q1[i], e1[i]);
         end
      end
      tests_run++;
      if (b0.overflow !== 1'b0) begin
         tests_failed++;
         $display("FAIL stream_ovf: got %b want 0", b0.overflow);
      end
   endtask

   task automatic test_cts_drain();
      logic [31:0] e [3];
      e = '{32'h0, 32'h11AA_8000, 32'h0000_0000};
      set_in(1'b1, 1'b0, 1'b1, 24'h123456);
      apply_reset();
      wait_ph(6'd40);
      b0.cts = 1'b0;
      collect(3);
      for (int i = 0; i < 3; i++) begin
         tests_run++;
         if (q0[i] !== e[i]) begin
            tests_failed++;
            $display("FAIL cts_drain_%0d: got %h want %h",
                     i, q0[i], e[i]);
         end
      end
   endtask

   task automatic test_sof();
      logic [31:0] e [4];
      e = '{32'h0, 32'h8FEF_8000, 32'h8FEF_C001, 32'h8FEF_8001};
      set_in(1'b1, 1'b0, 1'b1, 24'h8fff7f);
      apply_reset();
      wait_ph(6'd40);
      b0.v_sync = 1'b1;
      collect(4);
      for (int i = 0; i < 4; i++) begin
         tests_run++;
         if (q0[i] !== e[i]) begin
            tests_failed++;
            $display("FAIL sof_%0d: got %h want %h", i, q0[i], e[i]);
         end
      end
   endtask

   task automatic test_sof_pending();
      logic [31:0] e [4];
      e = '{32'h0, 32'h0000_0001, 32'h8FEF_C001, 32'h8FEF_8001};
      set_in(1'b0, 1'b1, 1'b1, 24'h8fff7f);
      apply_reset();
      wait_ph(6'd40);
      b0.cts = 1'b1;
      collect(4);
      for (int i = 0; i < 4; i++) begin
         tests_run++;
         if (q0[i] !== e[i]) begin
            tests_failed++;
            $display("FAIL sof_pend_%0d: got %h want %h",
                     i, q0[i], e[i]);
         end
      end
   endtask

   task automatic test_overflow();
      set_in(1'b1, 1'b0, 1'b1, 24'h8fff7f);
      apply_reset();
      wait_ph(6'd20);
      force u2.fifo_full = 1'b1;
      wait_ph(6'd40);
      release u2.fifo_full;
      tests_run++;
      if (b2.overflow !== 1'b1) begin
         tests_failed++;
         $display("FAIL ovf_set: got %b want 1", b2.overflow);
      end
      tests_run++;
      if (b0.overflow !== 1'b0) begin
         tests_failed++;
         $display("FAIL ovf_other: got %b want 0", b0.overflow);
      end
      wait_ph(6'd40);
      wait_ph(6'd40);
      tests_run++;
      if (b2.overflow !== 1'b1) begin
         tests_failed++;
         $display("FAIL ovf_sticky: got %b want 1", b2.overflow);
      end
   endtask

   task automatic test_reset_midword();
      logic [3:0] pre;
      logic [4:0] o;
      wait_ph(6'd33);
      pre = {b0.pclk, b0.i2s_bclk, b0.i2s_ws, b0.i2s_data};
      tests_run++;
      if (pre !== 4'b1111) begin
         tests_failed++;
         $display("FAIL midword_pre: got %b want 1111", pre);
      end
      b0.cts = 1'b0;
      reset  = 1'b1;
      @(negedge mclk);
      o = {b0.pclk, b0.i2s_bclk, b0.i2s_ws, b0.i2s_data, b0.overflow};
      tests_run++;
      if (o !== 5'b0) begin
         tests_failed++;
         $display("FAIL midword_outputs: got %b want 00000", o);
      end
      tests_run++;
      if (b2.overflow !== 1'b0) begin
         tests_failed++;
         $display("FAIL midword_ovf_clear: got %b want 0", b2.overflow);
      end
      reset = 1'b0;
      q0.delete();
      q1.delete();
      collect(2);
      for (int i = 0; i < 2; i++) begin
         tests_run++;
         if (q0[i] !== 32'h0) begin
            tests_failed++;
            $display("FAIL midword_frame%0d: got %h want 00000000",
                     i, q0[i]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_idle();
      test_protocol();
      test_pixel_stream();
      test_cts_drain();
      test_sof();
      test_sof_pending();
      test_overflow();
      test_reset_midword();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
